// File: rtl/adder_pkg.sv
// adder_pkg: FSM states and counter sizing shared by the multicycle adder
package adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
  function automatic int cnt_width(input int width, input int chunk);
    return (width / chunk > 1) ? $clog2(width / chunk) : 1;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit ripple chain of full-adder cells, also exposing the carry into its top bit
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  always_comb begin
    s = '0;
    co = ci;
    c_msb = ci;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb = co;
      s[i] = a[i] ^ b[i] ^ co;
      co = (a[i] & b[i]) | (co & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract over WIDTH/CHUNK cycles with a registered carry chain
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = cnt_width(WIDTH, CHUNK);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state, next;
  logic [WIDTH-1:0] a_sr, b_sr, acc, sum_next;
  logic [CW-1:0] cnt;
  logic carry, co, c_msb;
  logic [CHUNK-1:0] s;
  logic [WIDTH+CHUNK-1:0] wide;
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a(a_sr[CHUNK-1:0]),
    .b(b_sr[CHUNK-1:0]),
    .ci(carry),
    .s(s),
    .co(co),
    .c_msb(c_msb)
  );
  // partial sums enter from the MSB side so the final chunk lands in the top bits
  assign wide = {s, acc};
  assign sum_next = wide[WIDTH+CHUNK-1:CHUNK];
  assign ready = state == IDLE;
  assign done = state == FIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    next = (state == IDLE) ? (start ? RUN : IDLE) :
           (state == RUN)  ? ((cnt == LAST) ? FIN : RUN) : IDLE;
  end
  // outputs load on the last RUN edge so they are already valid while DONE is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      acc <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b1;
    end else if (state == IDLE && start) begin
      a_sr <= opa;
      b_sr <= sub ? ~opb : opb;
      carry <= sub | cin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> CHUNK;
      b_sr <= b_sr >> CHUNK;
      acc <= sum_next;
      carry <= co;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        result <= sum_next;
        cout <= co;
        overflow <= co ^ c_msb;
        zero <= sum_next == '0;
      end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: random and directed checks of several adder configurations against an arithmetic model
module tb_multicycle_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [5];
  logic sb [5];
  logic ci [5];
  logic [15:0] a [5];
  logic [15:0] b [5];
  logic rdy [5];
  logic dn [5];
  logic co [5];
  logic ov [5];
  logic zr [5];
  logic [15:0] rs [5];
  logic [7:0] r0, r1, r2, r3;
  logic [15:0] r4;
  int total = 0;
  int bad = 0;
  int chunk_of [5] = '{1, 2, 4, 8, 4};
  always #5 clk = ~clk;
  assign rs[0] = {8'd0, r0};
  assign rs[1] = {8'd0, r1};
  assign rs[2] = {8'd0, r2};
  assign rs[3] = {8'd0, r3};
  assign rs[4] = r4;
  multicycle_adder #(.WIDTH(8), .CHUNK(1)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]), .cin(ci[0]),
    .opa(a[0][7:0]), .opb(b[0][7:0]), .ready(rdy[0]), .done(dn[0]), .result(r0), .cout(co[0]), .overflow(ov[0]), .zero(zr[0]));
  multicycle_adder #(.WIDTH(8), .CHUNK(2)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]), .cin(ci[1]),
    .opa(a[1][7:0]), .opb(b[1][7:0]), .ready(rdy[1]), .done(dn[1]), .result(r1), .cout(co[1]), .overflow(ov[1]), .zero(zr[1]));
  multicycle_adder #(.WIDTH(8), .CHUNK(4)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb[2]), .cin(ci[2]),
    .opa(a[2][7:0]), .opb(b[2][7:0]), .ready(rdy[2]), .done(dn[2]), .result(r2), .cout(co[2]), .overflow(ov[2]), .zero(zr[2]));
  multicycle_adder #(.WIDTH(8), .CHUNK(8)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sb[3]), .cin(ci[3]),
    .opa(a[3][7:0]), .opb(b[3][7:0]), .ready(rdy[3]), .done(dn[3]), .result(r3), .cout(co[3]), .overflow(ov[3]), .zero(zr[3]));
  multicycle_adder #(.WIDTH(16), .CHUNK(4)) u4 (.clk(clk), .rst_n(rst_n), .start(st[4]), .sub(sb[4]), .cin(ci[4]),
    .opa(a[4]), .opb(b[4]), .ready(rdy[4]), .done(dn[4]), .result(r4), .cout(co[4]), .overflow(ov[4]), .zero(zr[4]));
  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // returns {overflow, zero, cout, result[15:0]} from plain signed/unsigned arithmetic
  function automatic logic [18:0] model(input int w, input logic s, input logic c, input logic [15:0] x, input logic [15:0] y);
    longint mask, ux, uy, full, sx, sy, sr, res;
    logic v;
    mask = (longint'(1) << w) - 1;
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
    full = s ? ux + ((~uy) & mask) + 1 : ux + uy + longint'(c);
    sx = (ux >= (longint'(1) << (w - 1))) ? ux - (longint'(1) << w) : ux;
    sy = (uy >= (longint'(1) << (w - 1))) ? uy - (longint'(1) << w) : uy;
    sr = s ? sx - sy : sx + sy + longint'(c);
    v = (sr > (longint'(1) << (w - 1)) - 1) || (sr < -(longint'(1) << (w - 1)));
    res = full & mask;
    return {v, res == 0, ((full >> w) & 1) == 1, 16'(res)};
  endfunction
  task automatic op(input int k, input logic s, input logic c, input logic [15:0] x, input logic [15:0] y,
                    output logic [18:0] obs);
    int w, n, lat;
    logic [18:0] exp;
    w = (k == 4) ? 16 : 8;
    n = w / chunk_of[k];
    exp = model(w, s, c, x, y);
    @(negedge clk);
    a[k] = x; b[k] = y; sb[k] = s; ci[k] = c; st[k] = 1'b1;
    chk("ready_idle", longint'(rdy[k]), 1);
    @(negedge clk);
    st[k] = 1'b0; a[k] = 16'($urandom); b[k] = 16'($urandom); sb[k] = ~s; ci[k] = ~c;
    lat = 1;
    chk("ready_busy", longint'(rdy[k]), 0);
    while (!dn[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, n + 1);
    obs = {ov[k], zr[k], co[k], rs[k]};
    chk("result_flags", longint'(obs), longint'(exp));
    @(negedge clk);
    chk("done_single", longint'(dn[k]), 0);
    chk("ready_back", longint'(rdy[k]), 1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [18:0] obs;
    logic [18:0] q [$];
    logic [15:0] x, y;
    logic s, c;
    int dones, last, seen;
    for (int k = 0; k < 5; k++) begin
      st[k] = 0; sb[k] = 0; ci[k] = 0; a[k] = 0; b[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("rst_ready", longint'(rdy[k]), 1);
      chk("rst_done", longint'(dn[k]), 0);
      chk("rst_result", longint'(rs[k]), 0);
      chk("rst_zero", longint'(zr[k]), 1);
      chk("rst_flags", longint'({co[k], ov[k]}), 0);
    end
    rst_n = 1'b1;
    op(1, 0, 0, 16'd100, 16'd27, obs);
    chk("add_100_27", longint'(obs), longint'({1'b0, 1'b0, 1'b0, 16'd127}));
    op(1, 0, 0, 16'h7F, 16'h01, obs);
    chk("add_ovf", longint'(obs), longint'({1'b1, 1'b0, 1'b0, 16'h80}));
    op(1, 0, 1, 16'hFF, 16'h01, obs);
    chk("add_cin", longint'(obs), longint'({1'b0, 1'b0, 1'b1, 16'h01}));
    op(1, 1, 0, 16'h05, 16'h05, obs);
    chk("sub_zero", longint'(obs), longint'({1'b0, 1'b1, 1'b1, 16'h00}));
    op(1, 1, 1, 16'h03, 16'h05, obs);
    chk("sub_borrow", longint'(obs), longint'({1'b0, 1'b0, 1'b0, 16'hFE}));
    op(1, 1, 0, 16'h80, 16'h01, obs);
    chk("sub_ovf", longint'(obs), longint'({1'b1, 1'b0, 1'b1, 16'h7F}));
    dones = 0; last = -1;
    @(negedge clk);
    st[1] = 1'b1;
    for (int cyc = 0; cyc < 80 && dones < 4; cyc++) begin
      if (rdy[1]) begin
        x = 16'($urandom); y = 16'($urandom); s = 1'($urandom); c = 1'($urandom);
        a[1] = x; b[1] = y; sb[1] = s; ci[1] = c;
        q.push_back(model(8, s, c, x, y));
      end else begin
        a[1] = 16'($urandom); b[1] = 16'($urandom); sb[1] = 1'($urandom); ci[1] = 1'($urandom);
      end
      @(negedge clk);
      if (dn[1]) begin
        obs = {ov[1], zr[1], co[1], rs[1]};
        chk("b2b_result", longint'(obs), q.size() > 0 ? longint'(q.pop_front()) : -1);
        if (last >= 0) chk("b2b_interval", cyc - last, 6);
        last = cyc;
        dones++;
      end
    end
    st[1] = 1'b0;
    chk("b2b_count", dones, 4);
    @(negedge clk);
    chk("b2b_idle", longint'(rdy[1]), 1);
    @(negedge clk);
    a[1] = 16'h12; b[1] = 16'h34; sb[1] = 0; ci[1] = 0; st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", longint'(rs[1]), 0);
    chk("abort_zero", longint'(zr[1]), 1);
    chk("abort_done", longint'(dn[1]), 0);
    chk("abort_ready", longint'(rdy[1]), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dn[1]) seen++;
    end
    chk("abort_no_done", seen, 0);
    op(1, 0, 0, 16'h21, 16'h43, obs);
    chk("after_abort", longint'(obs), longint'({1'b0, 1'b0, 1'b0, 16'h64}));
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 20; i++)
        op(k, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), obs);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor for the datapath ALU. Two WIDTH-bit operands are processed CHUNK bits per clock through a registered carry chain over WIDTH/CHUNK cycles. The block provides start/ready/done handshaking and carry, signed-overflow and zero flags. It generalises the single-bit full-adder cell into a width- and speed-configurable arithmetic unit, for use where a full-width ripple chain would not close timing.

## Interface
- WIDTH, 8: operand/result width in bits; must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 2: bits summed per clock cycle; 1 ≤ CHUNK ≤ WIDTH.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  request; accepted only in a cycle where READY=1.
- SUB  input  1  0: OPA+OPB+CIN; 1: OPA−OPB, computed as OPA+~OPB+1 (CIN ignored).
- CIN  input  1  carry-in for add mode.
- OPA, OPB  input  WIDTH  operands; sampled only on acceptance.
- READY  output  1  high in IDLE.
- DONE  output  1  one-cycle pulse; RESULT and flags are valid from this cycle.
- RESULT  output  WIDTH  sum/difference.
- COUT  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- OVERFLOW  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- ZERO  output  1  RESULT == 0.

## Operation
- N = WIDTH/CHUNK.
- States:
  - IDLE: READY=1. START=1 latches OPA, the effective B (OPB or ~OPB) and the initial carry (CIN, or 1 when SUB=1); clears the chunk counter; moves to RUN.
  - RUN: each cycle adds the low CHUNK bits of the A and B shift registers plus the registered carry. The partial sum shifts into the result register from the MSB side. The carry is registered, and the counter increments. After chunk N−1, the state moves to FIN.
  - FIN: RESULT, COUT, OVERFLOW and ZERO are written to output registers; DONE=1. Always returns to IDLE next cycle.
- START while READY=0 is ignored: not queued, no effect.
- SUB and CIN are sampled only on acceptance; changes during RUN have no effect.
- OVERFLOW uses the carry into bit WIDTH−1, captured during the final chunk.
- Output registers hold their values from one FIN until the next FIN.
- Reset values: READY=1 (state IDLE); DONE, RESULT, COUT, OVERFLOW = 0; ZERO = 1 (consistent with RESULT=0). Internal shift registers, carry and counter are cleared.
- Reset asserted mid-operation aborts immediately: no DONE pulse, outputs return to reset values, and the block is in IDLE once RESET_N deasserts.

## Timing
- START accepted at the edge ending cycle t.
- RUN occupies cycles t+1 … t+N.
- DONE=1 and outputs are updated in cycle t+N+1.
- READY=1 again in cycle t+N+2, giving a maximum throughput of one operation per N+2 cycles.
- CHUNK=WIDTH gives N=1: DONE at t+2.
- The combinational path is limited to a CHUNK-bit ripple chain plus register setup.
- DONE is never asserted in two consecutive cycles.

## Structure
- Shared package adder_pkg holds:
  - the state encoding constants IDLE/RUN/FIN (2 bits);
  - the function computing the counter width from WIDTH/CHUNK.
- Sub-module chunk_adder (parameter CHUNK): CHUNK-bit ripple adder of full-adder cells with inputs A, B, CI and outputs S, CO, plus C_MSB, the carry into its top bit, used for OVERFLOW.
- Top level contains the FSM, counter, operand shift registers, carry register and output registers.

## Test plan
- WIDTH=8, CHUNK=2, add: OPA=100, OPB=27, CIN=0 → DONE at t+5; RESULT=127, COUT=0, OVERFLOW=0, ZERO=0; READY low for cycles t+1…t+5.
- Signed overflow and carry-in:
  - OPA=0x7F, OPB=0x01 → RESULT=0x80, OVERFLOW=1, COUT=0.
  - OPA=0xFF, OPB=0x01, CIN=1 → RESULT=0x01, COUT=1, OVERFLOW=0.
- Subtract:
  - 0x05−0x05 → RESULT=0x00, ZERO=1, COUT=1.
  - 0x03−0x05 → RESULT=0xFE, COUT=0.
  - 0x80−0x01 → RESULT=0x7F, OVERFLOW=1.
- START held high continuously, with OPA/OPB/SUB changing during RUN: only the values sampled at acceptance are used. Back-to-back operations complete every N+2 cycles, and DONE pulses exactly once per operation.
- Assert RESET_N low during RUN chunk 2: no DONE pulse; outputs read reset values (RESULT=0, ZERO=1). After release, READY=1 and a new operation completes correctly.
- Parameter sweep, random operands vs. a reference model: CHUNK ∈ {1,2,4,8} at WIDTH=8, and WIDTH=16/CHUNK=4. Check DONE latency = N+1 cycles after acceptance, plus bit-exact RESULT/COUT/OVERFLOW/ZERO.
